// File: rtl/button_gesture_decoder_pkg.sv
// rtl/button_gesture_decoder_pkg.sv - shared state encoding and default tick constants
package button_gesture_decoder_pkg;

  // 3-bit binary state encoding, shared with board top-levels
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    SWALLOW   = 3'd3,
    LONG_HOLD = 3'd4
  } gesture_state_e;

  localparam int DEF_LONG_TICKS   = 500;
  localparam int DEF_DCLICK_TICKS = 250;
  localparam int DEF_REPEAT_TICKS = 100;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/button_gesture_decoder_if.sv
// rtl/button_gesture_decoder_if.sv - debounced button inputs and gesture event outputs
interface button_gesture_decoder_if;
  logic TICK;
  logic PB_STATE;
  logic PB_DOWN;
  logic PB_UP;
  logic SHORT_PRESS;
  logic DOUBLE_CLICK;
  logic LONG_PRESS;
  logic REPEAT;
  logic HELD;

  // Debounce/timebase side: drives the button and tick, consumes events
  modport master (
    output TICK, PB_STATE, PB_DOWN, PB_UP,
    input  SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT, HELD
  );

  // Decoder side
  modport slave (
    input  TICK, PB_STATE, PB_DOWN, PB_UP,
    output SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT, HELD
  );
endinterface

// File: rtl/button_gesture_decoder_gesture_timer.sv
// rtl/button_gesture_decoder_gesture_timer.sv - tick counter with sync clear and threshold hit
module gesture_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             hit_o
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a tick so a state change always restarts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The Nth tick is the one that arrives while N-1 ticks have been counted
  assign hit_o = tick_i && (cnt_q == (thresh_i - ONE));
endmodule

// File: rtl/button_gesture_decoder.sv
// rtl/button_gesture_decoder.sv - press-gesture FSM with registered event outputs
module button_gesture_decoder
  import button_gesture_decoder_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                     CLK,
  input logic                     RST_N,
  button_gesture_decoder_if.slave bus
);
  localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_TICKS);

  gesture_state_e   state_q, state_d;
  logic [CNT_W-1:0] thresh;
  logic             timed;
  logic             tick_en;
  logic             hit;
  logic             clr;
  logic             short_d, short_q;
  logic             dbl_d, dbl_q;
  logic             long_d, long_q;
  logic             rep_d, rep_q;
  logic             held_d, held_q;

  // Threshold for the current state; IDLE and SWALLOW never count
  always_comb begin
    thresh = '0;
    timed  = 1'b0;
    case (state_q)
      PRESS1:    begin thresh = LONG_T;   timed = 1'b1; end
      WAIT2:     begin thresh = DCLICK_T; timed = 1'b1; end
      LONG_HOLD: begin thresh = REPEAT_T; timed = 1'b1; end
      default:   begin thresh = '0;       timed = 1'b0; end
    endcase
  end

  assign tick_en = bus.TICK & timed;

  gesture_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .clr_i   (clr),
    .tick_i  (tick_en),
    .thresh_i(thresh),
    .hit_o   (hit)
  );

  // Next state and event decode; edges beat threshold hits, missed releases abort silently
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PB_DOWN && !bus.PB_UP) state_d = PRESS1;
      end
      PRESS1: begin
        if (bus.PB_UP) begin
          state_d = WAIT2;
        end else if (!bus.PB_STATE) begin
          state_d = IDLE;
        end else if (hit) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
        end
      end
      WAIT2: begin
        if (bus.PB_DOWN) begin
          dbl_d   = 1'b1;
          state_d = SWALLOW;
        end else if (hit) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      SWALLOW: begin
        if (bus.PB_UP || !bus.PB_STATE) state_d = IDLE;
      end
      LONG_HOLD: begin
        if (bus.PB_UP || !bus.PB_STATE) begin
          state_d = IDLE;
        end else if (hit) begin
          rep_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A repeat restarts the period without leaving LONG_HOLD
  assign clr    = (state_d != state_q) | rep_d;
  assign held_d = (state_d == LONG_HOLD);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered output stage
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      short_q <= short_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  assign bus.SHORT_PRESS  = short_q;
  assign bus.DOUBLE_CLICK = dbl_q;
  assign bus.LONG_PRESS   = long_q;
  assign bus.REPEAT       = rep_q;
  assign bus.HELD         = held_q;
endmodule

// File: tb/tb_button_gesture_decoder.sv
// tb/tb_button_gesture_decoder.sv - self-checking bench for button_gesture_decoder
module tb_button_gesture_decoder;
  localparam int LONG   = 5;
  localparam int DCLICK = 3;
  localparam int REP    = 2;
  localparam int TPER   = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  button_gesture_decoder_if bus ();

  button_gesture_decoder #(
    .LONG_TICKS  (LONG),
    .DCLICK_TICKS(DCLICK),
    .REPEAT_TICKS(REP),
    .CNT_W       (16)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_short = 0, n_dbl = 0, n_long = 0, n_rep = 0;
  int tick_ph = 0;
  bit chk_en = 1'b0;

  // Reference model: gesture described by elapsed ticks since press/release
  bit   m_active, m_pressed, m_long, m_dbl;
  int   m_t;
  logic e_short, e_dbl, e_long, e_rep, e_held;

  initial begin
    m_active = 0; m_pressed = 0; m_long = 0; m_dbl = 0; m_t = 0;
    e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0; e_held = 0;
    forever begin
      @(posedge CLK);
      e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0;
      if (!RST_N) begin
        m_active = 0;
      end else if (!m_active) begin
        if (bus.PB_DOWN && !bus.PB_UP) begin
          m_active = 1; m_pressed = 1; m_long = 0; m_dbl = 0; m_t = 0;
        end
      end else if (m_dbl) begin
        if (bus.PB_UP || !bus.PB_STATE) m_active = 0;
      end else if (m_pressed) begin
        if (bus.PB_UP) begin
          if (m_long) m_active = 0;
          else begin m_pressed = 0; m_t = 0; end
        end else if (!bus.PB_STATE) begin
          m_active = 0;
        end else if (bus.TICK) begin
          m_t++;
          if (!m_long && m_t == LONG) begin
            e_long = 1; m_long = 1;
          end else if (m_long && ((m_t - LONG) % REP) == 0) begin
            e_rep = 1;
          end
        end
      end else begin
        if (bus.PB_DOWN) begin
          e_dbl = 1; m_dbl = 1; m_pressed = 1;
        end else if (bus.TICK) begin
          m_t++;
          if (m_t == DCLICK) begin
            e_short = 1; m_active = 0;
          end
        end
      end
      e_held = m_active && m_pressed && m_long && !m_dbl;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_cycle();
    check("short_press", bus.SHORT_PRESS, e_short);
    check("double_click", bus.DOUBLE_CLICK, e_dbl);
    check("long_press", bus.LONG_PRESS, e_long);
    check("repeat", bus.REPEAT, e_rep);
    check("held", bus.HELD, e_held);
    check("one_pulse_max",
          32'(($countones({bus.SHORT_PRESS, bus.DOUBLE_CLICK, bus.LONG_PRESS, bus.REPEAT}) <= 1)), 1);
    if (bus.SHORT_PRESS === 1'b1)  n_short++;
    if (bus.DOUBLE_CLICK === 1'b1) n_dbl++;
    if (bus.LONG_PRESS === 1'b1)   n_long++;
    if (bus.REPEAT === 1'b1)       n_rep++;
  endtask

  // One clock of stimulus; outputs seen here reflect the previous step's inputs
  task automatic step(input bit d, input bit u, input bit s, input bit rn = 1'b1);
    @(negedge CLK);
    if (chk_en) compare_cycle();
    tick_ph      = (tick_ph + 1) % TPER;
    bus.TICK     = (tick_ph == 0);
    bus.PB_DOWN  = d;
    bus.PB_UP    = u;
    bus.PB_STATE = s;
    RST_N        = rn;
  endtask

  task automatic wait_ticks(input int n, input bit s);
    int seen = 0;
    while (seen < n) begin
      step(0, 0, s);
      if (bus.TICK) seen++;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic up_on_tick();
    bit done = 0;
    while (!done) begin
      if (((tick_ph + 1) % TPER) == 0) begin
        step(0, 1, 0);
        done = 1;
      end else begin
        step(0, 0, 1);
      end
    end
  endtask

  initial begin
    int b_s, b_d, b_l, b_r;
    bit lvl;
    int r;
    bus.TICK = 0; bus.PB_DOWN = 0; bus.PB_UP = 0; bus.PB_STATE = 0;
    step(0, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 0);
    check("reset_outputs",
          {bus.SHORT_PRESS, bus.DOUBLE_CLICK, bus.LONG_PRESS, bus.REPEAT, bus.HELD}, 0);
    step(0, 0, 0);
    settle(6);

    // Short press
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = n_rep;
    step(1, 0, 1); wait_ticks(2, 1); step(0, 1, 0); wait_ticks(3, 0); settle(6);
    check("s1_short", n_short - b_s, 1);
    check("s1_others", (n_dbl - b_d) + (n_long - b_l) + (n_rep - b_r), 0);

    // Double click, then long hold without long press
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = n_rep;
    step(1, 0, 1); step(0, 1, 0); wait_ticks(1, 0); step(1, 0, 1);
    wait_ticks(10, 1); step(0, 1, 0); settle(6);
    check("s2_double", n_dbl - b_d, 1);
    check("s2_no_long", n_long - b_l, 0);
    check("s2_no_short", n_short - b_s, 0);

    // Long press with repeats
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = n_rep;
    step(1, 0, 1); wait_ticks(5, 1); wait_ticks(4, 1); step(0, 0, 1);
    check("s3_held_level", bus.HELD, 1);
    step(0, 1, 0); step(0, 0, 0);
    check("s3_held_falls", bus.HELD, 0);
    settle(20);
    check("s3_long", n_long - b_l, 1);
    check("s3_repeats", n_rep - b_r, 2);
    check("s3_no_short", n_short - b_s, 0);

    // Release coincident with the long threshold tick
    b_s = n_short; b_l = n_long;
    step(1, 0, 1); wait_ticks(4, 1); up_on_tick(); wait_ticks(3, 0); settle(6);
    check("s4_no_long", n_long - b_l, 0);
    check("s4_short", n_short - b_s, 1);

    // Reset during WAIT2 drops the gesture
    b_s = n_short;
    step(1, 0, 1); wait_ticks(1, 1); step(0, 1, 0); step(0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0);
    check("s5_reset_outputs",
          {bus.SHORT_PRESS, bus.DOUBLE_CLICK, bus.LONG_PRESS, bus.REPEAT, bus.HELD}, 0);
    wait_ticks(6, 0); settle(6);
    check("s5_no_short", n_short - b_s, 0);

    // Missed release edge, then a normal click
    b_s = n_short; b_d = n_dbl; b_l = n_long; b_r = n_rep;
    step(1, 0, 1); step(0, 0, 0); wait_ticks(6, 0);
    check("s6_no_pulses", (n_short - b_s) + (n_dbl - b_d) + (n_long - b_l) + (n_rep - b_r), 0);
    step(1, 0, 1); wait_ticks(1, 1); step(0, 1, 0); wait_ticks(3, 0); settle(6);
    check("s6_short", n_short - b_s, 1);

    // Randomized debounced button traffic against the model
    lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        step(0, 0, lvl, 0);
      end else if (r < 40) begin
        lvl = !lvl;
        if (lvl) step(1, 0, 1);
        else     step(0, 1, 0);
      end else if (r < 43 && lvl) begin
        lvl = 0;
        step(0, 0, 0);
      end else if (r < 46 && !lvl) begin
        step(1, 1, 0);
      end else begin
        step(0, 0, lvl);
      end
    end
    settle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
